// File: rtl/imm_decode_stage.sv
// Immediate generator between fetch and register read: decodes, sign-extends and classifies the immediate.
// Latency 1 cycle from accepted input to out_valid; full throughput while out_ready is high.
// Backpressure: main + skid entries; in_ready = ~skid_valid (registered), so no combinational ready path.
// Optional feature macro: IMMGEN_ZIMM_EN (CSR immediate decode for opcode 1110011).

module imm_decode_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [31:0]      out_instr,
   output logic [TAG_W-1:0] out_tag
);

   // Immediate format codes as seen by the register-read stage.
   typedef enum logic [2:0] {
      FMT_I    = 3'd0,
      FMT_S    = 3'd1,
      FMT_B    = 3'd2,
      FMT_U    = 3'd3,
      FMT_J    = 3'd4,
      FMT_Z    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   // RV base opcodes that carry an immediate.
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef IMMGEN_ZIMM_EN
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

   // One pipeline entry: everything the consumer sees on out_*.
   typedef struct packed {
      logic [XLEN-1:0]  imm;
      fmt_e             fmt;
      logic [31:0]      instr;
      logic [TAG_W-1:0] tag;
   } entry_t;

   localparam entry_t RST_ENTRY = '{imm: '0, fmt: FMT_NONE, instr: '0, tag: '0};

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_vld_q, main_vld_d;
   logic   skid_vld_q, skid_vld_d;

   logic [31:0] imm32;
   fmt_e        dec_fmt;
   entry_t      dec_entry;
   logic        acc;
   logic        pop;

   // Decode the incoming instruction into a 32-bit immediate and its format.
   // Every format fits in 32 bits sign-extended from instr[31] (Z is zero-extended
   // by construction since its bit 31 is 0), so widening to XLEN is one sign extension.
   always_comb begin
      imm32   = '0;
      dec_fmt = FMT_NONE;
      unique case (in_instr[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_IMM_32: begin
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_fmt = FMT_I;
         end
         OP_STORE: begin
            imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            dec_fmt = FMT_S;
         end
         OP_BRANCH: begin
            imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
            dec_fmt = FMT_B;
         end
         OP_LUI, OP_AUIPC: begin
            imm32   = {in_instr[31:12], 12'b0};
            dec_fmt = FMT_U;
         end
         OP_JAL: begin
            imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
            dec_fmt = FMT_J;
         end
`ifdef IMMGEN_ZIMM_EN
         OP_SYSTEM: begin
            // funct3[2] selects the CSR-immediate variants (rs1 field is the uimm).
            if (in_instr[14]) begin
               imm32   = {27'b0, in_instr[19:15]};
               dec_fmt = FMT_Z;
            end else begin
               imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
               dec_fmt = FMT_I;
            end
         end
`endif
         default: begin
            imm32   = '0;
            dec_fmt = FMT_NONE;
         end
      endcase
   end

   // Assemble the decoded entry; the signed cast replicates bit 31 up to XLEN.
   always_comb begin
      dec_entry       = RST_ENTRY;
      dec_entry.imm   = XLEN'($signed(imm32));
      dec_entry.fmt   = dec_fmt;
      dec_entry.instr = in_instr;
      dec_entry.tag   = in_tag;
   end

   assign acc = in_valid & ~skid_vld_q;
   assign pop = main_vld_q & out_ready;

   // Entry movement: flush wins, then pop/accept. An accept is only possible
   // while the skid is empty, so a pop that promotes the skid never coincides
   // with a new entry arriving.
   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (pop) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
         end else if (acc) begin
            main_d = dec_entry;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (acc) begin
         if (!main_vld_q) begin
            main_d     = dec_entry;
            main_vld_d = 1'b1;
         end else begin
            skid_d     = dec_entry;
            skid_vld_d = 1'b1;
         end
      end
   end

   // State registers; data holds whenever the entry is not replaced, which keeps
   // out_* stable while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= RST_ENTRY;
         skid_q     <= RST_ENTRY;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign in_ready  = ~skid_vld_q;
   assign out_valid = main_vld_q;
   assign out_imm   = main_q.imm;
   assign out_fmt   = main_q.fmt;
   assign out_instr = main_q.instr;
   assign out_tag   = main_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share one stimulus stream.
// A queue-based occupancy model plus arithmetic immediate reference is compared every cycle.
// Directed vectors are additionally pinned with hand-computed literal expectations.

module tb_imm_decode_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [31:0] in_tag;

   logic        in_ready32, out_valid32;
   logic [31:0] out_imm32;
   logic [2:0]  out_fmt32;
   logic [31:0] out_instr32, out_tag32;

   logic        in_ready64, out_valid64;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt64;
   logic [31:0] out_instr64, out_tag64;

   imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
      .out_fmt(out_fmt32), .out_instr(out_instr32), .out_tag(out_tag32)
   );

   imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
      .out_fmt(out_fmt64), .out_instr(out_instr64), .out_tag(out_tag64)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] tag;
   } txn_t;

   txn_t mq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Two's-complement interpretation of an unsigned field of the given width.
   function automatic longint sx(input longint v, input int bits);
      longint half;
      half = longint'(1) << (bits - 1);
      return (v >= half) ? v - 2 * half : v;
   endfunction

   // Reference immediate as a 64-bit value, built by weighting the fields.
   function automatic longint ref_imm(input logic [31:0] i);
      longint v;
      v = 0;
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h1B: v = sx(longint'(i[31:20]), 12);
         7'h23: v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
         7'h63: v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                       + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
         7'h37, 7'h17: v = sx(longint'(i[31:12]) * 4096, 32);
         7'h6F: v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
                       + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
`ifdef IMMGEN_ZIMM_EN
         7'h73: v = i[14] ? longint'(i[19:15]) : sx(longint'(i[31:20]), 12);
`endif
         default: v = 0;
      endcase
      return v;
   endfunction

   function automatic int ref_fmt(input logic [31:0] i);
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h1B: return 0;
         7'h23: return 1;
         7'h63: return 2;
         7'h37, 7'h17: return 3;
         7'h6F: return 4;
`ifdef IMMGEN_ZIMM_EN
         7'h73: return i[14] ? 5 : 0;
`endif
         default: return 7;
      endcase
   endfunction

   // Occupancy model: up to two held transactions in arrival order.
   always @(posedge clk or negedge rst_n) begin
      int sz;
      txn_t t;
      if (!rst_n) begin
         mq.delete();
      end else begin
         sz = mq.size();
         if (flush) begin
            mq.delete();
         end else begin
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && sz < 2) begin
               t.instr = in_instr;
               t.tag   = in_tag;
               mq.push_back(t);
            end
         end
      end
   end

   // Compare process: DUT outputs against the model on every cycle out of reset.
   always @(negedge clk) begin
      txn_t   t;
      longint e;
      if (chk_en && rst_n) begin
         chk("in_ready32", 64'(in_ready32), 64'(mq.size() < 2));
         chk("in_ready64", 64'(in_ready64), 64'(mq.size() < 2));
         chk("out_valid32", 64'(out_valid32), 64'(mq.size() > 0));
         chk("out_valid64", 64'(out_valid64), 64'(mq.size() > 0));
         if (mq.size() > 0) begin
            t = mq[0];
            e = ref_imm(t.instr);
            chk("imm32", 64'(out_imm32), 64'(e) & 64'hFFFF_FFFF);
            chk("imm64", out_imm64, 64'(e));
            chk("fmt32", 64'(out_fmt32), 64'(ref_fmt(t.instr)));
            chk("fmt64", 64'(out_fmt64), 64'(ref_fmt(t.instr)));
            chk("instr32", 64'(out_instr32), 64'(t.instr));
            chk("tag32", 64'(out_tag32), 64'(t.tag));
            chk("tag64", 64'(out_tag64), 64'(t.tag));
         end
      end
   end

   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                      input logic ordy, input logic fl);
      in_valid  = v;
      in_instr  = ins;
      in_tag    = tg;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_valid32"}, 64'(out_valid32), 64'd0);
      chk({pfx, "_rdy32"}, 64'(in_ready32), 64'd1);
      chk({pfx, "_imm32"}, 64'(out_imm32), 64'd0);
      chk({pfx, "_fmt32"}, 64'(out_fmt32), 64'd7);
      chk({pfx, "_instr32"}, 64'(out_instr32), 64'd0);
      chk({pfx, "_tag32"}, 64'(out_tag32), 64'd0);
      chk({pfx, "_valid64"}, 64'(out_valid64), 64'd0);
      chk({pfx, "_imm64"}, out_imm64, 64'd0);
      chk({pfx, "_fmt64"}, 64'(out_fmt64), 64'd7);
      chk({pfx, "_tag64"}, 64'(out_tag64), 64'd0);
   endtask

   localparam logic [31:0] I_ADDI   = 32'hFFF0_0093;
   localparam logic [31:0] I_BEQ    = 32'hFE00_0EE3;
   localparam logic [31:0] I_JAL    = 32'hFF9F_F06F;
   localparam logic [31:0] I_LUI    = 32'h8000_0037;
   localparam logic [31:0] I_CSRRWI = 32'h0052_D073;

   logic [31:0] tbl [0:13] = '{
      32'hFFF0_0093, 32'hFE00_0EE3, 32'hFF9F_F06F, 32'h8000_0037,
      32'h0052_D073, 32'hFE11_2E23, 32'h0020_9463, 32'h0100_006F,
      32'h0000_1297, 32'h0041_2083, 32'h0000_80E7, 32'hFFF0_809B,
      32'h3000_22F3, 32'h0020_81B3
   };

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst");
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // Pin the reference model with hand-worked immediates.
      chk("ref_sw", 64'(ref_imm(32'hFE11_2E23)), 64'hFFFF_FFFF_FFFF_FFFC);
      chk("ref_bne", 64'(ref_imm(32'h0020_9463)), 64'd8);
      chk("ref_jal", 64'(ref_imm(32'h0100_006F)), 64'd16);

      // Directed vectors with literal expectations.
      cyc(1, I_ADDI, 32'd10, 1, 0);
      chk("addi_vld", 64'(out_valid32), 64'd1);
      chk("addi_imm", 64'(out_imm32), 64'hFFFF_FFFF);
      chk("addi_fmt", 64'(out_fmt32), 64'd0);
      cyc(1, I_BEQ, 32'd11, 1, 0);
      chk("beq_imm", 64'(out_imm32), 64'hFFFF_FFFC);
      chk("beq_fmt", 64'(out_fmt32), 64'd2);
      cyc(1, I_JAL, 32'd12, 1, 0);
      chk("jal_imm", 64'(out_imm32), 64'hFFFF_FFF8);
      chk("jal_fmt", 64'(out_fmt32), 64'd4);
      chk("jal_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFF8);
      cyc(1, I_LUI, 32'd13, 1, 0);
      chk("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
      chk("lui_imm32", 64'(out_imm32), 64'h8000_0000);
      chk("lui_fmt", 64'(out_fmt64), 64'd3);
      cyc(1, I_CSRRWI, 32'd14, 1, 0);
`ifdef IMMGEN_ZIMM_EN
      chk("csr_imm", 64'(out_imm32), 64'd5);
      chk("csr_fmt", 64'(out_fmt32), 64'd5);
`else
      chk("csr_imm", 64'(out_imm32), 64'd0);
      chk("csr_fmt", 64'(out_fmt32), 64'd7);
`endif
      cyc(0, '0, '0, 1, 0);
      chk("drain_vld", 64'(out_valid32), 64'd0);

      // Back-pressure: two accepted, third held, then released in order.
      cyc(1, I_ADDI, 32'd1, 0, 0);
      cyc(1, I_BEQ, 32'd2, 0, 0);
      chk("bp_rdy_low", 64'(in_ready32), 64'd0);
      cyc(1, I_JAL, 32'd3, 0, 0);
      chk("bp_hold_tag", 64'(out_tag32), 64'd1);
      chk("bp_hold_imm", 64'(out_imm32), 64'hFFFF_FFFF);
      cyc(1, I_JAL, 32'd3, 1, 0);
      chk("bp_tag2", 64'(out_tag32), 64'd2);
      chk("bp_rdy_high", 64'(in_ready32), 64'd1);
      cyc(1, I_JAL, 32'd3, 1, 0);
      chk("bp_tag3", 64'(out_tag32), 64'd3);
      chk("bp_vld3", 64'(out_valid32), 64'd1);
      cyc(0, '0, '0, 1, 0);
      cyc(0, '0, '0, 1, 0);

      // Mixed traffic with irregular handshakes.
      for (int i = 0; i < 200; i++) begin
         cyc(($urandom_range(3) != 0), tbl[i % 14], 32'd100 + 32'(i),
             ($urandom_range(2) != 0), 0);
      end
      repeat (3) cyc(0, '0, '0, 1, 0);

      // Flush with both entries held.
      cyc(1, I_ADDI, 32'd20, 0, 0);
      cyc(1, I_BEQ, 32'd21, 0, 0);
      chk("fl_full", 64'(in_ready32), 64'd0);
      cyc(1, I_JAL, 32'd22, 0, 1);
      chk("fl_vld", 64'(out_valid32), 64'd0);
      chk("fl_rdy", 64'(in_ready32), 64'd1);
      cyc(0, '0, '0, 1, 0);
      chk("fl_dropped", 64'(out_valid64), 64'd0);

      // Asynchronous reset in the middle of a stalled stream.
      cyc(1, I_LUI, 32'd30, 0, 0);
      cyc(1, I_JAL, 32'd31, 0, 0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("arst");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      cyc(1, I_ADDI, 32'd40, 1, 0);
      chk("post_rst_tag", 64'(out_tag32), 64'd40);
      cyc(0, '0, '0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
